// File: rtl/vanilla_scoreboard_latency_tracker_pkg.sv
// Shared types for the vanilla scoreboard latency tracker: pending-reason categories,
// the default-configuration retire record and a width helper.
package vanilla_scoreboard_tracker_pkg;

  typedef enum logic [2:0] {
    SBL_IDIV_FDIV     = 3'd0,
    SBL_DRAM_LOAD     = 3'd1,
    SBL_GLOBAL_LOAD   = 3'd2,
    SBL_GROUP_LOAD    = 3'd3,
    SBL_DRAM_AMO      = 3'd4,
    SBL_GROUP_AMO     = 3'd5,
    SBL_DMEM_OVERFLOW = 3'd6,
    SBL_RESERVED      = 3'd7
  } vanilla_sbl_cat_e;

  localparam int unsigned sbl_def_id_w  = 5;
  localparam int unsigned sbl_def_cat_w = 8;
  localparam int unsigned sbl_def_lat_w = 16;

  typedef struct packed {
    logic [sbl_def_id_w-1:0]  id;
    logic [sbl_def_cat_w-1:0] cat;
    logic [sbl_def_lat_w-1:0] lat;
  } vanilla_sbl_retire_s;

  function automatic int unsigned sbl_safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vanilla_scoreboard_latency_tracker_if.sv
// Set/clear request and monitor-output bundle for the scoreboard latency tracker.
// master drives set/clear (core side), slave is the tracker.
interface vanilla_scoreboard_latency_tracker_if #(
  parameter int unsigned els_p       = 32,
  parameter int unsigned num_rf_p    = 2,
  parameter int unsigned num_cat_p   = 8,
  parameter int unsigned age_width_p = 16
) ();
  localparam int unsigned id_width_lp  = vanilla_scoreboard_tracker_pkg::sbl_safe_clog2(els_p);
  localparam int unsigned rf_width_lp  = vanilla_scoreboard_tracker_pkg::sbl_safe_clog2(num_rf_p);
  localparam int unsigned cnt_width_lp = $clog2(num_rf_p*els_p+1);

  logic                                  set_v_i;
  logic [rf_width_lp-1:0]                set_rf_i;
  logic [id_width_lp-1:0]                set_id_i;
  logic [num_cat_p-1:0]                  set_cat_i;
  logic [num_rf_p-1:0]                   clear_v_i;
  logic [num_rf_p*id_width_lp-1:0]       clear_id_i;
  logic [num_rf_p*els_p*num_cat_p-1:0]   sb_o;
  logic [num_rf_p*els_p-1:0]             pending_o;
  logic [num_cat_p*cnt_width_lp-1:0]     cat_count_o;
  logic [num_rf_p-1:0]                   retire_v_o;
  logic [num_rf_p*id_width_lp-1:0]       retire_id_o;
  logic [num_rf_p*num_cat_p-1:0]         retire_cat_o;
  logic [num_rf_p*age_width_p-1:0]       retire_lat_o;
  logic                                  double_set_o;
  logic                                  spurious_clear_o;
  logic                                  hang_o;

  modport master (
    output set_v_i, set_rf_i, set_id_i, set_cat_i, clear_v_i, clear_id_i,
    input  sb_o, pending_o, cat_count_o, retire_v_o, retire_id_o, retire_cat_o,
           retire_lat_o, double_set_o, spurious_clear_o, hang_o
  );

  modport slave (
    input  set_v_i, set_rf_i, set_id_i, set_cat_i, clear_v_i, clear_id_i,
    output sb_o, pending_o, cat_count_o, retire_v_o, retire_id_o, retire_cat_o,
           retire_lat_o, double_set_o, spurious_clear_o, hang_o
  );
endinterface

// File: rtl/vanilla_scoreboard_latency_tracker_entry.sv
// One scoreboard register: category flags plus a saturating age counter.
// Event outputs are combinational; the top level registers them.
module vanilla_sbl_entry #(
  parameter int unsigned num_cat_p   = 8,
  parameter int unsigned age_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   set_i,
  input  logic                   clear_i,
  input  logic [num_cat_p-1:0]   cat_i,
  output logic [num_cat_p-1:0]   flags_o,
  output logic [age_width_p-1:0] age_o,
  output logic                   retire_o,
  output logic                   spurious_o,
  output logic                   double_o
);
  logic [num_cat_p-1:0]   r_flags;
  logic [age_width_p-1:0] r_age;
  logic                   w_pending;
  logic                   w_set;
  logic [age_width_p-1:0] w_age_inc;

  assign w_pending  = |r_flags;
  assign w_set      = set_i && (|cat_i);
  assign w_age_inc  = (&r_age) ? r_age : r_age + 1'b1;
  assign retire_o   = clear_i && w_pending;
  assign spurious_o = clear_i && !w_pending;
  assign double_o   = w_set && !clear_i && w_pending;
  assign flags_o    = r_flags;
  assign age_o      = r_age;

  // A same-cycle clear retires the old contents first, so the set installs fresh.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n_i) begin
      r_flags <= '0;
      r_age   <= '0;
    end else if (w_set && (clear_i || !w_pending)) begin
      r_flags <= cat_i;
      r_age   <= age_width_p'(1);
    end else if (clear_i) begin
      r_flags <= '0;
      r_age   <= '0;
    end else if (w_pending) begin
      if (w_set) r_flags <= r_flags | cat_i;
      r_age <= w_age_inc;
    end
  end
endmodule

// File: rtl/vanilla_scoreboard_latency_tracker.sv
// Scoreboard monitor: num_rf_p*els_p entries, category reductions, per-RF retire records
// and sticky protocol/hang flags. Flat layout: sb_o bit (rf*els_p+id)*num_cat_p+cat.
module vanilla_scoreboard_latency_tracker
  import vanilla_scoreboard_tracker_pkg::*;
#(
  parameter int unsigned els_p       = 32,
  parameter int unsigned num_rf_p    = 2,
  parameter int unsigned num_cat_p   = 8,
  parameter int unsigned age_width_p = 16,
  parameter int unsigned timeout_p   = 4096
) (
  input  logic clk_i,
  input  logic reset_n_i,
  vanilla_scoreboard_latency_tracker_if.slave bus
);
  localparam int unsigned id_width_lp  = sbl_safe_clog2(els_p);
  localparam int unsigned rf_width_lp  = sbl_safe_clog2(num_rf_p);
  localparam int unsigned cnt_width_lp = $clog2(num_rf_p*els_p+1);
  localparam logic [age_width_p-1:0] timeout_lp = age_width_p'(timeout_p);

  logic [num_cat_p-1:0]   w_flags  [num_rf_p][els_p];
  logic [age_width_p-1:0] w_age    [num_rf_p][els_p];
  logic                   w_retire [num_rf_p][els_p];
  logic                   w_spur   [num_rf_p][els_p];
  logic                   w_double [num_rf_p][els_p];

  for (genvar r = 0; r < num_rf_p; r++) begin : g_rf
    for (genvar e = 0; e < els_p; e++) begin : g_el
      logic w_set_hit;
      logic w_clear_hit;
      assign w_set_hit   = bus.set_v_i && (bus.set_rf_i == rf_width_lp'(r))
                        && (bus.set_id_i == id_width_lp'(e));
      assign w_clear_hit = bus.clear_v_i[r]
                        && (bus.clear_id_i[r*id_width_lp +: id_width_lp] == id_width_lp'(e));
      vanilla_sbl_entry #(.num_cat_p(num_cat_p), .age_width_p(age_width_p)) u_entry (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .set_i      (w_set_hit),
        .clear_i    (w_clear_hit),
        .cat_i      (bus.set_cat_i),
        .flags_o    (w_flags[r][e]),
        .age_o      (w_age[r][e]),
        .retire_o   (w_retire[r][e]),
        .spurious_o (w_spur[r][e]),
        .double_o   (w_double[r][e])
      );
    end
  end

  logic [num_rf_p*els_p*num_cat_p-1:0] w_sb;
  logic [num_rf_p*els_p-1:0]           w_pending;
  logic [cnt_width_lp-1:0]             w_cat_count [num_cat_p];
  logic [num_rf_p-1:0]                 w_rf_ret_v;
  logic [num_cat_p-1:0]                w_rf_ret_cat [num_rf_p];
  logic [age_width_p-1:0]              w_rf_ret_lat [num_rf_p];
  logic                                w_any_double, w_any_spur, w_any_hang;

  always_comb begin
    // NOTE: every variable gets a default before the loops so no latch is inferred.
    w_sb         = '0;
    w_pending    = '0;
    w_rf_ret_v   = '0;
    w_any_double = 1'b0;
    w_any_spur   = 1'b0;
    w_any_hang   = 1'b0;
    for (int c = 0; c < num_cat_p; c++) w_cat_count[c] = '0;
    for (int r = 0; r < num_rf_p; r++) begin
      w_rf_ret_cat[r] = '0;
      w_rf_ret_lat[r] = '0;
      for (int e = 0; e < els_p; e++) begin
        w_sb[(r*els_p+e)*num_cat_p +: num_cat_p] = w_flags[r][e];
        w_pending[r*els_p+e] = |w_flags[r][e];
        // At most one entry per RF retires per cycle, so OR-merging its record is exact.
        if (w_retire[r][e]) begin
          w_rf_ret_v[r]   = 1'b1;
          w_rf_ret_cat[r] = w_rf_ret_cat[r] | w_flags[r][e];
          w_rf_ret_lat[r] = w_rf_ret_lat[r] | w_age[r][e];
        end
        w_any_double = w_any_double | w_double[r][e];
        w_any_spur   = w_any_spur | w_spur[r][e];
        w_any_hang   = w_any_hang | ((|w_flags[r][e]) && (w_age[r][e] == timeout_lp));
        for (int c = 0; c < num_cat_p; c++)
          w_cat_count[c] = w_cat_count[c] + cnt_width_lp'(w_flags[r][e][c]);
      end
    end
  end

  logic [num_rf_p-1:0]             r_retire_v;
  logic [num_rf_p*id_width_lp-1:0] r_retire_id;
  logic [num_rf_p*num_cat_p-1:0]   r_retire_cat;
  logic [num_rf_p*age_width_p-1:0] r_retire_lat;
  logic                            r_double, r_spur, r_hang;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_retire_v   <= '0;
      r_retire_id  <= '0;
      r_retire_cat <= '0;
      r_retire_lat <= '0;
      r_double     <= 1'b0;
      r_spur       <= 1'b0;
      r_hang       <= 1'b0;
    end else begin
      r_retire_v <= w_rf_ret_v;
      for (int r = 0; r < num_rf_p; r++) begin
        if (w_rf_ret_v[r]) begin
          r_retire_id[r*id_width_lp +: id_width_lp] <= bus.clear_id_i[r*id_width_lp +: id_width_lp];
          r_retire_cat[r*num_cat_p +: num_cat_p]    <= w_rf_ret_cat[r];
          r_retire_lat[r*age_width_p +: age_width_p] <= w_rf_ret_lat[r];
        end
      end
      r_double <= r_double | w_any_double;
      r_spur   <= r_spur | w_any_spur;
      r_hang   <= r_hang | w_any_hang;
    end
  end

  always_comb begin
    bus.cat_count_o = '0;
    for (int c = 0; c < num_cat_p; c++)
      bus.cat_count_o[c*cnt_width_lp +: cnt_width_lp] = w_cat_count[c];
  end

  assign bus.sb_o             = w_sb;
  assign bus.pending_o        = w_pending;
  assign bus.retire_v_o       = r_retire_v;
  assign bus.retire_id_o      = r_retire_id;
  assign bus.retire_cat_o     = r_retire_cat;
  assign bus.retire_lat_o     = r_retire_lat;
  assign bus.double_set_o     = r_double;
  assign bus.spurious_clear_o = r_spur;
  assign bus.hang_o           = r_hang;
endmodule

// File: tb/tb_vanilla_scoreboard_latency_tracker.sv
// Directed bench: a default tracker plus a narrow-age instance for saturation and hang.
module tb_vanilla_scoreboard_latency_tracker;
  import vanilla_scoreboard_tracker_pkg::*;

  logic clk_i = 1'b0;
  logic reset_n_i;
  always #5 clk_i = ~clk_i;

  vanilla_scoreboard_latency_tracker_if d_if ();
  vanilla_scoreboard_latency_tracker_if #(.els_p(4), .age_width_p(4)) s_if ();

  vanilla_scoreboard_latency_tracker u_dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (d_if.slave)
  );

  vanilla_scoreboard_latency_tracker #(.els_p(4), .age_width_p(4), .timeout_p(10)) u_sat (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (s_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_all();
    d_if.set_v_i = 1'b0; d_if.set_rf_i = '0; d_if.set_id_i = '0; d_if.set_cat_i = '0;
    d_if.clear_v_i = '0; d_if.clear_id_i = '0;
    s_if.set_v_i = 1'b0; s_if.set_rf_i = '0; s_if.set_id_i = '0; s_if.set_cat_i = '0;
    s_if.clear_v_i = '0; s_if.clear_id_i = '0;
  endtask

  task automatic d_set(input int rf, input int id, input logic [7:0] cat);
    d_if.set_v_i = 1'b1; d_if.set_rf_i = 1'(rf); d_if.set_id_i = 5'(id); d_if.set_cat_i = cat;
  endtask

  task automatic d_clear(input int rf, input int id);
    d_if.clear_v_i[rf] = 1'b1;
    d_if.clear_id_i[rf*5 +: 5] = 5'(id);
  endtask

  function automatic logic [63:0] d_flags(input int rf, input int id);
    return 64'(d_if.sb_o[(rf*32+id)*8 +: 8]);
  endfunction

  function automatic logic [63:0] d_cnt(input int c);
    return 64'(d_if.cat_count_o[c*7 +: 7]);
  endfunction

  task automatic check_retire(input string tag, input int rf, input vanilla_sbl_retire_s exp);
    check({tag, "_v"},   64'(d_if.retire_v_o[rf]), 64'd1);
    check({tag, "_id"},  64'(d_if.retire_id_o[rf*5 +: 5]), 64'(exp.id));
    check({tag, "_cat"}, 64'(d_if.retire_cat_o[rf*8 +: 8]), 64'(exp.cat));
    check({tag, "_lat"}, 64'(d_if.retire_lat_o[rf*16 +: 16]), 64'(exp.lat));
  endtask

  task automatic check_no_errors(input string tag);
    check({tag, "_dbl"}, 64'(d_if.double_set_o), 64'd0);
    check({tag, "_spur"}, 64'(d_if.spurious_clear_o), 64'd0);
  endtask

  initial begin
    logic [7:0] cat_dram, cat_glob, cat_grp;
    cat_dram = 8'(1 << int'(SBL_DRAM_LOAD));
    cat_glob = 8'(1 << int'(SBL_GLOBAL_LOAD));
    cat_grp  = 8'(1 << int'(SBL_GROUP_LOAD));

    reset_n_i = 1'b0;
    idle_all();
    tick(); tick();
    check("rst_sb",      64'(|d_if.sb_o), 64'd0);
    check("rst_retv",    64'(d_if.retire_v_o), 64'd0);
    check("rst_hang",    64'(d_if.hang_o), 64'd0);
    reset_n_i = 1'b1;
    tick();

    // Basic latency: set rf0 id5 cat 0x02, clear 7 cycles later.
    d_set(0, 5, cat_dram);
    tick();
    idle_all();
    check("basic_cnt_t1", d_cnt(1), 64'd1);
    check("basic_pend",   64'(d_if.pending_o[5]), 64'd1);
    for (int i = 0; i < 6; i++) tick();
    check("basic_cnt_t7", d_cnt(1), 64'd1);
    d_clear(0, 5);
    tick();
    idle_all();
    check_retire("basic", 0, '{id: 5'd5, cat: 8'h02, lat: 16'd7});
    check("basic_cnt_t8", d_cnt(1), 64'd0);
    check("basic_pend_clr", 64'(d_if.pending_o[5]), 64'd0);
    tick();
    check("basic_pulse", 64'(d_if.retire_v_o[0]), 64'd0);
    check("basic_hold",  64'(d_if.retire_lat_o[15:0]), 64'd7);

    // Same-cycle set and clear on rf1 id3 after 4 cycles pending.
    d_set(1, 3, cat_glob);
    tick();
    idle_all();
    check("sc_flags_old", d_flags(1, 3), 64'h04);
    tick(); tick(); tick();
    d_set(1, 3, cat_grp);
    d_clear(1, 3);
    tick();
    idle_all();
    check_retire("sc", 1, '{id: 5'd3, cat: 8'h04, lat: 16'd4});
    check("sc_flags_new", d_flags(1, 3), 64'h08);
    check_no_errors("sc");
    d_clear(1, 3);
    tick();
    idle_all();
    check_retire("sc_age1", 1, '{id: 5'd3, cat: 8'h08, lat: 16'd1});

    // Dual-RF clears in one cycle with different ages.
    d_set(0, 1, 8'h01);
    tick();
    idle_all();
    d_set(1, 1, 8'h20);
    tick();
    idle_all();
    tick(); tick();
    d_clear(0, 1);
    d_clear(1, 1);
    tick();
    idle_all();
    check("dual_v", 64'(d_if.retire_v_o), 64'h3);
    check_retire("dual0", 0, '{id: 5'd1, cat: 8'h01, lat: 16'd4});
    check_retire("dual1", 1, '{id: 5'd1, cat: 8'h20, lat: 16'd3});
    check_no_errors("dual");

    // Spurious clear, double set, zero-mask set.
    d_clear(0, 9);
    tick();
    idle_all();
    check("spur_flag", 64'(d_if.spurious_clear_o), 64'd1);
    check("spur_noret", 64'(d_if.retire_v_o), 64'd0);
    check("spur_nodbl", 64'(d_if.double_set_o), 64'd0);
    d_set(0, 2, 8'h01);
    tick();
    d_set(0, 2, 8'h10);
    tick();
    idle_all();
    check("dbl_flags", d_flags(0, 2), 64'h11);
    check("dbl_flag",  64'(d_if.double_set_o), 64'd1);
    d_set(0, 7, 8'h00);
    tick();
    idle_all();
    check("zero_mask", 64'(d_if.pending_o[7]), 64'd0);

    // Mid-run asynchronous reset with entries pending.
    d_set(1, 4, 8'h40);
    tick();
    idle_all();
    #2 reset_n_i = 1'b0;
    #1;
    check("mrst_sb",   64'(|d_if.sb_o), 64'd0);
    check("mrst_pend", 64'(|d_if.pending_o), 64'd0);
    check("mrst_dbl",  64'(d_if.double_set_o), 64'd0);
    check("mrst_spur", 64'(d_if.spurious_clear_o), 64'd0);
    check("mrst_lat",  64'(d_if.retire_lat_o), 64'd0);
    check("mrst_cnt",  64'(d_if.cat_count_o), 64'd0);
    tick(); tick();
    reset_n_i = 1'b1;
    tick();
    check("mrst_noret", 64'(d_if.retire_v_o), 64'd0);
    d_clear(0, 2);
    tick();
    idle_all();
    check("mrst_clr_noret", 64'(d_if.retire_v_o), 64'd0);
    check("mrst_clr_spur",  64'(d_if.spurious_clear_o), 64'd1);

    // Saturation and hang on the 4-bit-age instance (timeout 10).
    s_if.set_v_i = 1'b1; s_if.set_rf_i = 1'b0; s_if.set_id_i = 2'd1; s_if.set_cat_i = 8'h01;
    tick();
    idle_all();
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("hang_early_%0d", i), 64'(s_if.hang_o), 64'd0);
    end
    tick();
    check("hang_rise", 64'(s_if.hang_o), 64'd1);
    for (int i = 0; i < 19; i++) tick();
    s_if.clear_v_i[0] = 1'b1; s_if.clear_id_i[1:0] = 2'd1;
    tick();
    idle_all();
    check("sat_v",    64'(s_if.retire_v_o[0]), 64'd1);
    check("sat_lat",  64'(s_if.retire_lat_o[3:0]), 64'd15);
    check("sat_hang_sticky", 64'(s_if.hang_o), 64'd1);
    check("dflt_nohang", 64'(d_if.hang_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
